// File: rtl/border_collision_ctrl.sv
// border_collision_ctrl
// Multi-ball border collision unit. For every ball channel it watches the
// border/ball drawing-request overlap, reflects the ball velocity (with
// optional damping) only when the ball is moving into the cushion it touches,
// and uses a per-ball contact FSM so a ball that keeps overlapping the
// cushion for many pixels/frames is reflected exactly once.
//
// Ports:
//   clk                 system clock
//   reset               asynchronous, active-high reset
//   frameStart          one-cycle pulse at the start of each frame
//   borderDR            border drawing request
//   ballDR              per-ball drawing request
//   ballTopLeftPosX/Y   packed signed positions, ball i at [i*POS_W +: POS_W]
//   ballVelX/Y          packed signed velocities, ball i at [i*VEL_W +: VEL_W]
//   clearCount          synchronous clear of hitCount
//   ballVelXOut/YOut    registered (possibly reflected) velocities
//   collisionOccurred   one-cycle pulse per accepted reflection, per ball
//   hitCount            saturating count of accepted reflections (all balls)
//   ballStateDbg        per-ball FSM state, ball i at [2*i +: 2]
//                       (0 = ARMED, 1 = CONTACT, 2 = COOLDOWN)
module border_collision_ctrl #(
  parameter int NUM_BALLS       = 4,
  parameter int POS_W           = 11,
  parameter int VEL_W           = 11,
  parameter int TOP_OFFSET      = 32,
  parameter int DOWN_OFFSET     = 440,
  parameter int LEFT_OFFSET     = 32,
  parameter int RIGHT_OFFSET    = 600,
  parameter int DAMP_SHIFT      = 3,
  parameter int COOLDOWN_FRAMES = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         frameStart,
  input  logic                         borderDR,
  input  logic [NUM_BALLS-1:0]         ballDR,
  input  logic [NUM_BALLS*POS_W-1:0]   ballTopLeftPosX,
  input  logic [NUM_BALLS*POS_W-1:0]   ballTopLeftPosY,
  input  logic [NUM_BALLS*VEL_W-1:0]   ballVelX,
  input  logic [NUM_BALLS*VEL_W-1:0]   ballVelY,
  input  logic                         clearCount,
  output logic [NUM_BALLS*VEL_W-1:0]   ballVelXOut,
  output logic [NUM_BALLS*VEL_W-1:0]   ballVelYOut,
  output logic [NUM_BALLS-1:0]         collisionOccurred,
  output logic [7:0]                   hitCount,
  output logic [NUM_BALLS*2-1:0]       ballStateDbg
);

  typedef enum logic [1:0] {
    ARMED    = 2'd0,
    CONTACT  = 2'd1,
    COOLDOWN = 2'd2
  } state_t;

  localparam int CNT_W = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;

  localparam logic signed [POS_W-1:0] TOP_S   = POS_W'(TOP_OFFSET);
  localparam logic signed [POS_W-1:0] DOWN_S  = POS_W'(DOWN_OFFSET);
  localparam logic signed [POS_W-1:0] LEFT_S  = POS_W'(LEFT_OFFSET);
  localparam logic signed [POS_W-1:0] RIGHT_S = POS_W'(RIGHT_OFFSET);

  localparam logic [VEL_W-1:0] VEL_MAX = {1'b0, {(VEL_W-1){1'b1}}};
  localparam logic [VEL_W-1:0] VEL_MIN = {1'b1, {(VEL_W-1){1'b0}}};

  // Reverse direction and damp. The most-negative value has no positive
  // counterpart, so its magnitude saturates to the largest positive value.
  function automatic logic [VEL_W-1:0] reflect_vel(input logic [VEL_W-1:0] v);
    logic [VEL_W-1:0] mag;
    logic [VEL_W-1:0] damped;
    if (v[VEL_W-1]) begin
      mag = (v == VEL_MIN) ? VEL_MAX : (~v + 1'b1);
    end else begin
      mag = v;
    end
    if (DAMP_SHIFT == 0) begin
      damped = mag;
    end else begin
      damped = mag - (mag >> DAMP_SHIFT);
    end
    reflect_vel = v[VEL_W-1] ? damped : (~damped + 1'b1);
  endfunction

  logic [NUM_BALLS-1:0] accept_vec;

  for (genvar i = 0; i < NUM_BALLS; i++) begin : g_ball
    logic signed [POS_W-1:0] px;
    logic signed [POS_W-1:0] py;
    logic [VEL_W-1:0]        vx;
    logic [VEL_W-1:0]        vy;
    logic                    hit;
    logic                    frame_hit;
    logic                    flip_x;
    logic                    flip_y;
    logic                    accept;
    logic                    vx_neg, vx_pos, vy_neg, vy_pos;
    logic [VEL_W-1:0]        vx_d, vy_d;
    logic [VEL_W-1:0]        vx_q, vy_q;
    logic                    pulse_q;
    logic                    overlap_q;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    state_t                  state_q, state_d;

    assign px  = ballTopLeftPosX[i*POS_W +: POS_W];
    assign py  = ballTopLeftPosY[i*POS_W +: POS_W];
    assign vx  = ballVelX[i*VEL_W +: VEL_W];
    assign vy  = ballVelY[i*VEL_W +: VEL_W];
    assign hit = ballDR[i] & borderDR;

    // A hit in the frameStart cycle still belongs to the frame that is ending.
    assign frame_hit = overlap_q | hit;

    // State register
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state_q   <= ARMED;
        cnt_q     <= '0;
        overlap_q <= 1'b0;
      end else begin
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        overlap_q <= frameStart ? 1'b0 : frame_hit;
      end
    end

    // Next-state logic
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
        ARMED: begin
          if (hit) state_d = CONTACT;
        end
        CONTACT: begin
          if (frameStart && !frame_hit) begin
            if (COOLDOWN_FRAMES == 0) begin
              state_d = ARMED;
            end else begin
              state_d = COOLDOWN;
              cnt_d   = CNT_W'(COOLDOWN_FRAMES);
            end
          end
        end
        COOLDOWN: begin
          // Touching the cushion again restarts the whole contact episode.
          if (hit) begin
            state_d = CONTACT;
          end else if (frameStart) begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) state_d = ARMED;
          end
        end
        default: state_d = ARMED;
      endcase
    end

    // Output logic: reflection is only evaluated on an ARMED hit
    always_comb begin
      vx_neg = vx[VEL_W-1];
      vx_pos = !vx[VEL_W-1] && (vx != '0);
      vy_neg = vy[VEL_W-1];
      vy_pos = !vy[VEL_W-1] && (vy != '0);
      flip_x = ((px <= LEFT_S) && vx_neg) || ((px >= RIGHT_S) && vx_pos);
      flip_y = ((py <= TOP_S)  && vy_neg) || ((py >= DOWN_S)  && vy_pos);
      accept = (state_q == ARMED) && hit;
      vx_d   = vx;
      vy_d   = vy;
      if (accept && flip_x) vx_d = reflect_vel(vx);
      if (accept && flip_y) vy_d = reflect_vel(vy);
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        vx_q    <= '0;
        vy_q    <= '0;
        pulse_q <= 1'b0;
      end else begin
        vx_q    <= vx_d;
        vy_q    <= vy_d;
        pulse_q <= accept;
      end
    end

    assign accept_vec[i]                  = accept;
    assign ballVelXOut[i*VEL_W +: VEL_W]  = vx_q;
    assign ballVelYOut[i*VEL_W +: VEL_W]  = vy_q;
    assign collisionOccurred[i]           = pulse_q;
    assign ballStateDbg[2*i +: 2]         = state_q;
  end

  // Hit counter: updated in the same cycle the pulses are registered.
  logic [8:0] n_acc;
  logic [8:0] sum;
  logic [7:0] count_d;
  logic [7:0] count_q;

  always_comb begin
    n_acc = '0;
    for (int k = 0; k < NUM_BALLS; k++) begin
      n_acc = n_acc + 9'(accept_vec[k]);
    end
    sum = {1'b0, count_q} + n_acc;
    if (clearCount) begin
      count_d = n_acc[8] ? 8'hFF : n_acc[7:0];
    end else begin
      count_d = sum[8] ? 8'hFF : sum[7:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign hitCount = count_q;

endmodule

// File: tb/tb_border_collision_ctrl.sv
// Testbench for border_collision_ctrl. Two instances run on the same stimulus:
// dut_a with default parameters, dut_b with DAMP_SHIFT=0, COOLDOWN_FRAMES=0.
// A behavioural model (per-ball "armed" flag plus a count of consecutive
// hit-free frames) predicts every output each cycle.
module tb_border_collision_ctrl;

  localparam int NB = 4;
  localparam int PW = 11;
  localparam int VW = 11;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // ---------------- stimulus signals ----------------
  logic            frame_start;
  logic            border_dr;
  logic [NB-1:0]   ball_dr;
  logic            clear_count;
  int              pos_x [NB];
  int              pos_y [NB];
  int              vel_x [NB];
  int              vel_y [NB];
  logic [NB*PW-1:0] pos_x_bus, pos_y_bus;
  logic [NB*VW-1:0] vel_x_bus, vel_y_bus;

  always_comb begin
    pos_x_bus = '0;
    pos_y_bus = '0;
    vel_x_bus = '0;
    vel_y_bus = '0;
    for (int i = 0; i < NB; i++) begin
      pos_x_bus[i*PW +: PW] = PW'(pos_x[i]);
      pos_y_bus[i*PW +: PW] = PW'(pos_y[i]);
      vel_x_bus[i*VW +: VW] = VW'(vel_x[i]);
      vel_y_bus[i*VW +: VW] = VW'(vel_y[i]);
    end
  end

  logic [NB*VW-1:0] a_vx, a_vy, b_vx, b_vy;
  logic [NB-1:0]    a_col, b_col;
  logic [7:0]       a_cnt, b_cnt;
  logic [NB*2-1:0]  a_dbg, b_dbg;

  border_collision_ctrl dut_a (
    .clk(clk), .reset(reset), .frameStart(frame_start), .borderDR(border_dr),
    .ballDR(ball_dr), .ballTopLeftPosX(pos_x_bus), .ballTopLeftPosY(pos_y_bus),
    .ballVelX(vel_x_bus), .ballVelY(vel_y_bus), .clearCount(clear_count),
    .ballVelXOut(a_vx), .ballVelYOut(a_vy), .collisionOccurred(a_col),
    .hitCount(a_cnt), .ballStateDbg(a_dbg)
  );

  border_collision_ctrl #(.DAMP_SHIFT(0), .COOLDOWN_FRAMES(0)) dut_b (
    .clk(clk), .reset(reset), .frameStart(frame_start), .borderDR(border_dr),
    .ballDR(ball_dr), .ballTopLeftPosX(pos_x_bus), .ballTopLeftPosY(pos_y_bus),
    .ballVelX(vel_x_bus), .ballVelY(vel_y_bus), .clearCount(clear_count),
    .ballVelXOut(b_vx), .ballVelYOut(b_vy), .collisionOccurred(b_col),
    .hitCount(b_cnt), .ballStateDbg(b_dbg)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d", tag, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int damp_p [2] = '{3, 0};
  int cool_p [2] = '{2, 0};
  int m_armed [2][NB];
  int m_quiet [2][NB];   // consecutive completed frames without a hit
  int m_ovl   [2][NB];   // a hit has been seen in the current frame
  int m_cnt   [2];

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_cnt[d] = 0;
      for (int i = 0; i < NB; i++) begin
        m_armed[d][i] = 1;
        m_quiet[d][i] = 0;
        m_ovl[d][i]   = 0;
      end
    end
    exp_q.delete();
  endtask

  function automatic int refl(int v, int p, int lo, int hi, int sh);
    int m, dm;
    if (!((p <= lo && v < 0) || (p >= hi && v > 0))) return v;
    m = (v < 0) ? -v : v;
    if (m > 1023) m = 1023;
    dm = (sh == 0) ? m : m - (m >> sh);
    return (v < 0) ? dm : -dm;
  endfunction

  // Predict the outputs after the next clock edge and advance the model.
  task automatic predict();
    for (int d = 0; d < 2; d++) begin
      int n = 0;
      int col = 0;
      int need = (cool_p[d] == 0) ? 1 : cool_p[d] + 1;
      for (int i = 0; i < NB; i++) begin
        int hit = (ball_dr[i] && border_dr) ? 1 : 0;
        int acc = (m_armed[d][i] != 0 && hit != 0) ? 1 : 0;
        int fh  = (m_ovl[d][i] != 0 || hit != 0) ? 1 : 0;
        int ex  = acc ? refl(vel_x[i], pos_x[i], 32, 600, damp_p[d]) : vel_x[i];
        int ey  = acc ? refl(vel_y[i], pos_y[i], 32, 440, damp_p[d]) : vel_y[i];
        int st;
        if (acc) begin
          m_armed[d][i] = 0;
          m_quiet[d][i] = 0;
        end else if (m_armed[d][i] == 0) begin
          if (frame_start) begin
            if (fh) m_quiet[d][i] = 0;
            else begin
              m_quiet[d][i]++;
              if (m_quiet[d][i] >= need) m_armed[d][i] = 1;
            end
          end else if (hit) begin
            m_quiet[d][i] = 0;
          end
        end
        m_ovl[d][i] = frame_start ? 0 : fh;
        st = m_armed[d][i] ? 0 : ((m_quiet[d][i] == 0) ? 1 : 2);
        exp_q.push_back(32'(ex & 32'h7FF));
        exp_q.push_back(32'(ey & 32'h7FF));
        exp_q.push_back(32'(st));
        n += acc;
        col |= acc << i;
      end
      if (clear_count) m_cnt[d] = n;
      else m_cnt[d] = (m_cnt[d] + n > 255) ? 255 : m_cnt[d] + n;
      exp_q.push_back(32'(col));
      exp_q.push_back(32'(m_cnt[d]));
    end
  endtask

  task automatic compare();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < NB; i++) begin
        check($sformatf("d%0d_velx%0d", d, i),
              d == 0 ? a_vx[i*VW +: VW] : b_vx[i*VW +: VW], exp_q.pop_front());
        check($sformatf("d%0d_vely%0d", d, i),
              d == 0 ? a_vy[i*VW +: VW] : b_vy[i*VW +: VW], exp_q.pop_front());
        check($sformatf("d%0d_state%0d", d, i),
              d == 0 ? a_dbg[2*i +: 2] : b_dbg[2*i +: 2], exp_q.pop_front());
      end
      check($sformatf("d%0d_collision", d), d == 0 ? a_col : b_col, exp_q.pop_front());
      check($sformatf("d%0d_hitcount", d), d == 0 ? a_cnt : b_cnt, exp_q.pop_front());
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    predict();
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic clear_inputs();
    frame_start = 1'b0;
    border_dr   = 1'b0;
    ball_dr     = '0;
    clear_count = 1'b0;
    for (int i = 0; i < NB; i++) begin
      pos_x[i] = 300;
      pos_y[i] = 200;
      vel_x[i] = 0;
      vel_y[i] = 0;
    end
  endtask

  task automatic idle_frames(input int n);
    ball_dr   = '0;
    border_dr = 1'b0;
    for (int f = 0; f < n; f++) begin
      for (int c = 0; c < 4; c++) begin
        frame_start = (c == 3);
        step();
      end
    end
    frame_start = 1'b0;
  endtask

  function automatic int pick_pos(int lo, int hi);
    case ($urandom_range(0, 4))
      0: return int'($urandom_range(0, 48)) - 8;
      1: return hi - 8 + int'($urandom_range(0, 16));
      2: return int'($urandom_range(0, 700));
      3: return lo;
      default: return hi;
    endcase
  endfunction

  function automatic int pick_vel();
    case ($urandom_range(0, 5))
      0: return -1024;
      1: return 0;
      2, 3: return int'($urandom_range(0, 2047)) - 1024;
      4: return int'($urandom_range(0, 40)) - 20;
      default: return 1023;
    endcase
  endfunction

  task automatic rand_balls(input int hit_pct);
    for (int i = 0; i < NB; i++) begin
      pos_x[i] = pick_pos(32, 600);
      pos_y[i] = pick_pos(32, 440);
      vel_x[i] = pick_vel();
      vel_y[i] = pick_vel();
      if (hit_pct == 0) ball_dr[i] = ($urandom_range(0, 1) == 1);
      else              ball_dr[i] = (int'($urandom_range(0, 99)) < hit_pct);
    end
    border_dr = (hit_pct == 0) ? 1'b0 : (int'($urandom_range(0, 99)) < 80);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1000000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    clear_inputs();
    reset = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_hitcount", a_cnt, 0);
    check("reset_state", a_dbg, 0);
    check("reset_velx", a_vx[VW-1:0], 0);
    check("reset_collision", a_col, 0);
    reset = 1'b0;

    // Single reflection from the left cushion
    pos_x[0] = 30; pos_y[0] = 200; vel_x[0] = -8; vel_y[0] = 3;
    ball_dr = 4'b0001; border_dr = 1'b1;
    step();
    check("dir_reflect_velx_a", a_vx[VW-1:0], 7);
    check("dir_reflect_velx_b", b_vx[VW-1:0], 8);
    check("dir_reflect_pulse", a_col, 1);
    check("dir_reflect_count", a_cnt, 1);

    // Held overlap over two frame boundaries: no further reflection
    for (int c = 0; c < 20; c++) begin
      frame_start = (c == 4 || c == 14);
      step();
    end
    frame_start = 1'b0;
    check("dir_hold_state", a_dbg[1:0], 1);
    check("dir_hold_count", a_cnt, 1);

    // Re-hit during cooldown: no pulse, back to contact
    idle_frames(2);
    check("dir_cooldown_state", a_dbg[1:0], 2);
    ball_dr = 4'b0001; border_dr = 1'b1;
    step();
    check("dir_cooldown_rehit_pulse", a_col, 0);
    check("dir_cooldown_rehit_state", a_dbg[1:0], 1);

    // Enough quiet frames to re-arm, then a ball already leaving
    idle_frames(4);
    check("dir_rearmed_state", a_dbg[1:0], 0);
    pos_x[0] = 30; vel_x[0] = 5;
    ball_dr = 4'b0001; border_dr = 1'b1;
    step();
    check("dir_leaving_velx", a_vx[VW-1:0], 5);
    check("dir_leaving_pulse", a_col, 1);

    // Corner hit flips both axes
    idle_frames(4);
    pos_x[0] = 30; pos_y[0] = 20; vel_x[0] = -16; vel_y[0] = -16;
    ball_dr = 4'b0001; border_dr = 1'b1;
    step();
    check("dir_corner_velx", a_vx[VW-1:0], 14);
    check("dir_corner_vely", a_vy[VW-1:0], 14);

    // Most-negative velocity saturates
    idle_frames(4);
    pos_x[0] = 30; pos_y[0] = 200; vel_x[0] = -1024; vel_y[0] = 0;
    ball_dr = 4'b0001; border_dr = 1'b1;
    step();
    check("dir_minvel_b", b_vx[VW-1:0], 1023);
    check("dir_minvel_a", a_vx[VW-1:0], 896);
    idle_frames(4);

    // Randomized traffic with varying hit density
    for (int c = 0; c < 2400; c++) begin
      int hp;
      case ((c / 64) % 3)
        0: hp = 0;
        1: hp = 15;
        default: hp = 60;
      endcase
      rand_balls(hp);
      frame_start = (c % 8 == 7);
      clear_count = ($urandom_range(0, 199) == 0);
      step();
    end
    clear_count = 1'b0;

    // Bursts of hits separated by quiet frames to drive the counter to saturation
    for (int c = 0; c < 1104; c++) begin
      rand_balls((c % 16) < 4 ? 100 : 0);
      if ((c % 16) < 4) border_dr = 1'b1;
      frame_start = (c % 4 == 3);
      step();
    end
    check("sat_count_a", a_cnt, 255);
    check("sat_count_b", b_cnt, 255);

    // All four balls hit in one cycle together with clearCount
    frame_start = 1'b0;
    rand_balls(100);
    border_dr = 1'b1;
    clear_count = 1'b1;
    step();
    clear_count = 1'b0;
    check("clear_with_hits_count", a_cnt, 4);
    check("clear_with_hits_pulses", a_col, 4'hF);

    // Asynchronous reset while the balls are in contact
    step();
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_state_a", a_dbg, 0);
    check("async_reset_state_b", b_dbg, 0);
    check("async_reset_count", a_cnt, 0);
    check("async_reset_pulses", a_col, 0);
    for (int i = 0; i < NB; i++) begin
      check($sformatf("async_reset_velx%0d", i), a_vx[i*VW +: VW], 0);
      check($sformatf("async_reset_vely%0d", i), a_vy[i*VW +: VW], 0);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();

    for (int c = 0; c < 200; c++) begin
      rand_balls(((c / 40) % 2 == 0) ? 50 : 0);
      frame_start = (c % 8 == 7);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
